// File: rtl/rq_tx_arbiter_pkg.sv
// Shared types and widths for the PCIe RQ transmit arbiter: FSM states,
// RQ stream widths and the beat-counter / grant-index widths.
package rq_tx_arbiter_pkg;

    localparam int RQ_DATA_W  = 512;
    localparam int RQ_KEEP_W  = 16;
    localparam int BEAT_CNT_W = 8;
    localparam int GRANT_W    = 3;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

    // Round-robin successor of a requester index, wrapping at num_req.
    function automatic logic [GRANT_W-1:0] next_idx(input logic [GRANT_W-1:0] idx,
                                                    input int num_req);
        return (int'(idx) == num_req - 1) ? '0 : idx + GRANT_W'(1);
    endfunction

endpackage

// File: rtl/rq_rr_picker.sv
// Combinational round-robin picker: first requesting index at or after
// rr_ptr, modulo NUM_REQ.
module rq_rr_picker
    import rq_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic [GRANT_W-1:0] sel,
    output logic               valid
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    int                   pos;

    // Rotating a doubled copy puts requester rr_ptr at bit 0.
    assign req_dbl = {req, req};
    assign req_rot = NUM_REQ'(req_dbl >> rr_ptr);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the unassigned paths infer latches.
    always_comb begin
        sel   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (req_rot[k]) begin
                sel   = GRANT_W'(pos);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rq_tx_arbiter.sv
// Round-robin arbiter that merges NUM_REQ requester FIFOs onto one PCIe RQ
// AXI-stream, holding the grant for a whole packet and flagging protocol errors.
module rq_tx_arbiter
    import rq_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BEATS = 64
) (
    input  logic                           user_clk,
    input  logic                           user_reset,
    input  logic [NUM_REQ-1:0]             i_req,
    output logic [NUM_REQ-1:0]             o_tkn,
    input  logic [NUM_REQ-1:0]             i_tvalid,
    input  logic [NUM_REQ*RQ_DATA_W-1:0]   i_tdata,
    input  logic [NUM_REQ-1:0]             i_tlast,
    input  logic [NUM_REQ*RQ_KEEP_W-1:0]   i_tkeep,
    output logic                           m_axis_rq_tvalid,
    output logic [RQ_DATA_W-1:0]           m_axis_rq_tdata,
    output logic                           m_axis_rq_tlast,
    output logic [RQ_KEEP_W-1:0]           m_axis_rq_tkeep,
    input  logic                           m_axis_rq_tready,
    output logic                           o_busy,
    output logic [2:0]                     o_grant_id,
    output logic                           o_err_novalid,
    output logic                           o_err_overlen
);

    arb_state_t            state_q, state_d;
    logic [GRANT_W-1:0]    grant_q, grant_d;
    logic [GRANT_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic                  err_novalid_q, err_overlen_q;

    logic [GRANT_W-1:0]    pick_idx;
    logic                  pick_valid;
    logic                  req_g, tvalid_g, tlast_g, tkn_g;
    logic                  novalid_set, overlen_set;

    rq_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req    (i_req),
        .rr_ptr (rr_ptr_q),
        .sel    (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        req_g    = 1'b0;
        tvalid_g = 1'b0;
        tlast_g  = 1'b0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (grant_q == GRANT_W'(n)) begin
                req_g    = i_req[n];
                tvalid_g = i_tvalid[n];
                tlast_g  = i_tlast[n];
            end
        end
    end

    // Tokens are suppressed while reset is held so no beat is popped mid-reset.
    assign tkn_g = (state_q == ST_XFER) && req_g && m_axis_rq_tready && !user_reset;

    always_comb begin
        for (int n = 0; n < NUM_REQ; n++) begin
            o_tkn[n] = tkn_g && (grant_q == GRANT_W'(n));
        end
    end

    // Only the token holder drives a non-zero slice, so an OR is a zero-latency mux.
    always_comb begin
        m_axis_rq_tdata = '0;
        m_axis_rq_tkeep = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            m_axis_rq_tdata = m_axis_rq_tdata | i_tdata[n*RQ_DATA_W +: RQ_DATA_W];
            m_axis_rq_tkeep = m_axis_rq_tkeep | i_tkeep[n*RQ_KEEP_W +: RQ_KEEP_W];
        end
    end

    assign m_axis_rq_tvalid = |i_tvalid;
    assign m_axis_rq_tlast  = |i_tlast;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_ARB: begin
                beat_cnt_d = '0;
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (tkn_g) begin
                    if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
                    if (tlast_g) begin
                        rr_ptr_d = next_idx(grant_q, NUM_REQ);
                        state_d  = ST_ARB;
                    end
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // The MAX_BEATS-th beat without tlast marks the packet overlength.
    assign overlen_set = tkn_g && !tlast_g && (int'(beat_cnt_q) >= MAX_BEATS - 1);
    assign novalid_set = tkn_g && !tvalid_g;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state_q       <= ST_ARB;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            beat_cnt_q    <= '0;
            err_novalid_q <= 1'b0;
            err_overlen_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            beat_cnt_q    <= beat_cnt_d;
            err_novalid_q <= err_novalid_q | novalid_set;
            err_overlen_q <= err_overlen_q | overlen_set;
        end
    end

    assign o_busy        = (state_q == ST_XFER);
    assign o_grant_id    = grant_q;
    assign o_err_novalid = err_novalid_q;
    assign o_err_overlen = err_overlen_q;

endmodule

// File: tb/tb_rq_tx_arbiter.sv
// Scoreboard bench for rq_tx_arbiter: requester models feed packets, the
// merged RQ stream is logged and compared against beats queued at load time.
module tb_rq_tx_arbiter;
    import rq_tx_arbiter_pkg::*;

    localparam int NR = 2;
    localparam int MB = 4;

    typedef struct packed {
        logic [2:0]           id;
        logic [RQ_DATA_W-1:0] data;
        logic [RQ_KEEP_W-1:0] keep;
        logic                 last;
    } beat_t;

    logic                      user_clk = 1'b0;
    logic                      user_reset;
    logic [NR-1:0]             i_req;
    logic [NR-1:0]             o_tkn;
    logic [NR-1:0]             i_tvalid;
    logic [NR*RQ_DATA_W-1:0]   i_tdata;
    logic [NR-1:0]             i_tlast;
    logic [NR*RQ_KEEP_W-1:0]   i_tkeep;
    logic                      m_axis_rq_tvalid;
    logic [RQ_DATA_W-1:0]      m_axis_rq_tdata;
    logic                      m_axis_rq_tlast;
    logic [RQ_KEEP_W-1:0]      m_axis_rq_tkeep;
    logic                      tready;
    logic                      o_busy;
    logic [2:0]                o_grant_id;
    logic                      o_err_novalid;
    logic                      o_err_overlen;

    beat_t         src_q [NR][$];
    beat_t         exp_q [$];
    beat_t         obs_q [$];
    beat_t         head  [NR];
    logic [NR-1:0] hv, gap, bad;

    logic [NR-1:0] s_tkn;
    logic          s_busy, s_tvalid, s_tlast, s_ovl, s_nov;
    logic [2:0]    s_grant;

    int checks   = 0;
    int failures = 0;

    always #5 user_clk = ~user_clk;

    rq_tx_arbiter #(.NUM_REQ(NR), .MAX_BEATS(MB)) dut (
        .user_clk         (user_clk),
        .user_reset       (user_reset),
        .i_req            (i_req),
        .o_tkn            (o_tkn),
        .i_tvalid         (i_tvalid),
        .i_tdata          (i_tdata),
        .i_tlast          (i_tlast),
        .i_tkeep          (i_tkeep),
        .m_axis_rq_tvalid (m_axis_rq_tvalid),
        .m_axis_rq_tdata  (m_axis_rq_tdata),
        .m_axis_rq_tlast  (m_axis_rq_tlast),
        .m_axis_rq_tkeep  (m_axis_rq_tkeep),
        .m_axis_rq_tready (tready),
        .o_busy           (o_busy),
        .o_grant_id       (o_grant_id),
        .o_err_novalid    (o_err_novalid),
        .o_err_overlen    (o_err_overlen)
    );

    // Requester slices follow their token combinationally, zero otherwise.
    for (genvar n = 0; n < NR; n++) begin : g_src
        assign i_tvalid[n] = o_tkn[n] & hv[n] & ~bad[n];
        assign i_tlast[n]  = o_tkn[n] & head[n].last;
        assign i_tdata[n*RQ_DATA_W +: RQ_DATA_W] = o_tkn[n] ? head[n].data : '0;
        assign i_tkeep[n*RQ_KEEP_W +: RQ_KEEP_W] = o_tkn[n] ? head[n].keep : '0;
    end

    task automatic load_pkt(input int id, input int pnum, input int nb, input bit push_exp);
        beat_t b;
        for (int i = 0; i < nb; i++) begin
            b.id   = 3'(id);
            b.data = {16{8'(id), 8'(pnum), 8'(i), 8'hA5}};
            b.last = (i == nb - 1);
            b.keep = b.last ? 16'h00FF : 16'hFFFF;
            src_q[id].push_back(b);
            if (push_exp) exp_q.push_back(b);
        end
    endtask

    // One clock: drive at negedge, sample #1 later, pop on the edge.
    task automatic step();
        beat_t ob;
        for (int n = 0; n < NR; n++) begin
            hv[n] = src_q[n].size() > 0;
            if (hv[n]) head[n] = src_q[n][0];
            i_req[n] = hv[n] && !gap[n];
        end
        #1;
        s_tkn = o_tkn; s_busy = o_busy; s_grant = o_grant_id;
        s_tvalid = m_axis_rq_tvalid; s_tlast = m_axis_rq_tlast;
        s_ovl = o_err_overlen; s_nov = o_err_novalid;
        if (o_tkn != '0) begin
            ob.id = o_tkn[1] ? 3'd1 : 3'd0;
            ob.data = m_axis_rq_tdata; ob.keep = m_axis_rq_tkeep; ob.last = m_axis_rq_tlast;
            obs_q.push_back(ob);
        end
        @(posedge user_clk);
        for (int n = 0; n < NR; n++) begin
            if (s_tkn[n] && src_q[n].size() > 0) ob = src_q[n].pop_front();
        end
        @(negedge user_clk);
    endtask

    task automatic clear_all();
        for (int n = 0; n < NR; n++) src_q[n].delete();
        exp_q.delete(); obs_q.delete();
        gap = '0; bad = '0;
    endtask

    task automatic do_reset();
        user_reset = 1'b1;
        clear_all();
        step(); step();
        user_reset = 1'b0;
    endtask

    task automatic test_reset();
        user_reset = 1'b1; tready = 1'b1;
        clear_all();
        load_pkt(0, 99, 2, 1'b0);
        step(); step();
        checks++;
        if (s_tkn !== 2'b00 || s_busy !== 1'b0) begin
            failures++; $display("FAIL reset_held tkn=%b busy=%b required tkn=00 busy=0", s_tkn, s_busy);
        end
        checks++;
        if ({s_grant, s_ovl, s_nov, s_tvalid} !== 6'd0) begin
            failures++; $display("FAIL reset_outputs grant=%0d ovl=%b nov=%b tvalid=%b required all 0", s_grant, s_ovl, s_nov, s_tvalid);
        end
        clear_all();
        user_reset = 1'b0;
        step();
        checks++;
        if (s_tkn !== 2'b00 || s_busy !== 1'b0) begin
            failures++; $display("FAIL reset_release tkn=%b busy=%b required tkn=00 busy=0", s_tkn, s_busy);
        end
    endtask

    task automatic test_single();
        beat_t e, o;
        logic [NR-1:0] et;
        load_pkt(0, 1, 3, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            et = (k >= 1 && k <= 3) ? 2'b01 : 2'b00;
            checks++;
            if (s_tkn !== et || s_busy !== (k >= 1 && k <= 3) || s_tlast !== (k == 3)) begin
                failures++; $display("FAIL single_cyc%0d tkn=%b busy=%b tlast=%b required tkn=%b busy=%b tlast=%b",
                                     k, s_tkn, s_busy, s_tlast, et, (k >= 1 && k <= 3), (k == 3));
            end
            if (k >= 1 && k <= 3) begin
                checks++;
                if (s_grant !== 3'd0) begin
                    failures++; $display("FAIL single_grant cyc%0d grant=%0d required 0", k, s_grant);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL single_sb missing beat id=%0d last=%b", e.id, e.last);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++; $display("FAIL single_sb got id=%0d d=%h k=%h l=%b required id=%0d d=%h k=%h l=%b",
                                         o.id, o.data[31:0], o.keep, o.last, e.id, e.data[31:0], e.keep, e.last);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL single_sb_extra beats=%0d required 0", obs_q.size());
        end
    endtask

    task automatic test_alternate();
        beat_t e, o;
        logic [NR-1:0] et;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            load_pkt(0, 10 + p, 1, 1'b1);
            load_pkt(1, 20 + p, 1, 1'b1);
        end
        for (int k = 0; k < 13; k++) begin
            step();
            if (k % 2 == 1 && k < 12) et = ((k / 2) % 2 == 0) ? 2'b01 : 2'b10;
            else et = 2'b00;
            checks++;
            if (s_tkn !== et) begin
                failures++; $display("FAIL alternate_cyc%0d tkn=%b required %b", k, s_tkn, et);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL alternate_sb missing beat id=%0d", e.id);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++; $display("FAIL alternate_sb got id=%0d d=%h required id=%0d d=%h",
                                         o.id, o.data[31:0], e.id, e.data[31:0]);
                end
            end
        end
    endtask

    task automatic test_stall();
        beat_t e, o;
        logic [NR-1:0] et;
        load_pkt(0, 30, 3, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tready = !(k >= 2 && k <= 5);
            step();
            et = (k == 1 || k == 6 || k == 7) ? 2'b01 : 2'b00;
            checks++;
            if (s_tkn !== et || s_busy !== (k >= 1 && k <= 7)) begin
                failures++; $display("FAIL stall_cyc%0d tkn=%b busy=%b required tkn=%b busy=%b", k, s_tkn, s_busy, et, (k >= 1 && k <= 7));
            end
            if (k >= 2 && k <= 5) begin
                checks++;
                if (s_tvalid !== 1'b0) begin
                    failures++; $display("FAIL stall_tvalid cyc%0d tvalid=%b required 0", k, s_tvalid);
                end
            end
        end
        tready = 1'b1;
        checks++;
        if (s_nov !== 1'b0 || s_ovl !== 1'b0) begin
            failures++; $display("FAIL stall_err nov=%b ovl=%b required 0 0", s_nov, s_ovl);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL stall_sb missing beat id=%0d", e.id);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++; $display("FAIL stall_sb got d=%h k=%h l=%b required d=%h k=%h l=%b",
                                         o.data[31:0], o.keep, o.last, e.data[31:0], e.keep, e.last);
                end
            end
        end
    endtask

    task automatic test_gap();
        beat_t e, o;
        logic [NR-1:0] exp_tk [11] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01,
                                       2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
        do_reset();
        load_pkt(0, 40, 3, 1'b1);
        load_pkt(1, 41, 2, 1'b1);
        for (int k = 0; k < 11; k++) begin
            gap[0] = (k == 2 || k == 3);
            step();
            checks++;
            if (s_tkn !== exp_tk[k]) begin
                failures++; $display("FAIL gap_cyc%0d tkn=%b required %b", k, s_tkn, exp_tk[k]);
            end
            if (k >= 1 && k <= 5) begin
                checks++;
                if (s_grant !== 3'd0 || s_busy !== 1'b1) begin
                    failures++; $display("FAIL gap_hold cyc%0d grant=%0d busy=%b required 0 1", k, s_grant, s_busy);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL gap_sb missing beat id=%0d", e.id);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++; $display("FAIL gap_sb got id=%0d d=%h required id=%0d d=%h",
                                         o.id, o.data[31:0], e.id, e.data[31:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        beat_t e, o;
        do_reset();
        load_pkt(0, 50, 1, 1'b0);
        step(); step(); step();
        load_pkt(0, 51, 3, 1'b0);
        step(); step();
        checks++;
        if (s_tkn !== 2'b01) begin
            failures++; $display("FAIL rstmid_beat1 tkn=%b required 01", s_tkn);
        end
        user_reset = 1'b1;
        clear_all();
        step();
        checks++;
        if (s_tkn !== 2'b00) begin
            failures++; $display("FAIL rstmid_during tkn=%b required 00", s_tkn);
        end
        user_reset = 1'b0;
        load_pkt(1, 52, 1, 1'b1);
        step();
        checks++;
        if (s_tkn !== 2'b00 || s_busy !== 1'b0 || s_grant !== 3'd0) begin
            failures++; $display("FAIL rstmid_after tkn=%b busy=%b grant=%0d required 00 0 0", s_tkn, s_busy, s_grant);
        end
        step();
        checks++;
        if (s_tkn !== 2'b10 || s_grant !== 3'd1) begin
            failures++; $display("FAIL rstmid_req1 tkn=%b grant=%0d required 10 1", s_tkn, s_grant);
        end
        step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL rstmid_sb missing beat id=%0d", e.id);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++; $display("FAIL rstmid_sb got id=%0d d=%h required id=%0d d=%h",
                                         o.id, o.data[31:0], e.id, e.data[31:0]);
                end
            end
        end
    endtask

    task automatic test_errors();
        beat_t e, o;
        do_reset();
        load_pkt(0, 60, 6, 1'b1);
        for (int k = 0; k < 9; k++) begin
            step();
            checks++;
            if (s_ovl !== (k >= 5) || s_busy !== (k >= 1 && k <= 6) || s_tkn !== ((k >= 1 && k <= 6) ? 2'b01 : 2'b00)) begin
                failures++; $display("FAIL overlen_cyc%0d ovl=%b busy=%b tkn=%b required ovl=%b busy=%b",
                                     k, s_ovl, s_busy, s_tkn, (k >= 5), (k >= 1 && k <= 6));
            end
        end
        checks++;
        if (s_nov !== 1'b0) begin
            failures++; $display("FAIL novalid_early nov=%b required 0", s_nov);
        end
        bad[1] = 1'b1;
        load_pkt(1, 61, 1, 1'b1);
        step(); step();
        checks++;
        if (s_tkn !== 2'b10 || s_tvalid !== 1'b0) begin
            failures++; $display("FAIL novalid_beat tkn=%b tvalid=%b required 10 0", s_tkn, s_tvalid);
        end
        step();
        checks++;
        if (s_nov !== 1'b1 || s_ovl !== 1'b1) begin
            failures++; $display("FAIL err_sticky nov=%b ovl=%b required 1 1", s_nov, s_ovl);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL errors_sb missing beat id=%0d", e.id);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++; $display("FAIL errors_sb got id=%0d d=%h required id=%0d d=%h",
                                         o.id, o.data[31:0], e.id, e.data[31:0]);
                end
            end
        end
        do_reset();
        step();
        checks++;
        if (s_nov !== 1'b0 || s_ovl !== 1'b0) begin
            failures++; $display("FAIL err_clear nov=%b ovl=%b required 0 0", s_nov, s_ovl);
        end
    endtask

    initial begin
        user_reset = 1'b1; tready = 1'b1;
        i_req = '0; hv = '0; gap = '0; bad = '0;
        @(negedge user_clk);
        test_reset();
        test_single();
        test_alternate();
        test_stall();
        test_gap();
        test_reset_mid();
        test_errors();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/rq_tx_arbiter.md
RQ_TX_ARBITER -- requirements
Module: rq_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (legal 2..8).
REQ-002 SHALL have parameter MAX_BEATS, default 64, maximum beats per packet before the overlength flag is raised (legal 2..255).
REQ-003 SHALL have port user_clk  in  1  sole clock; all logic is on the rising edge.
REQ-004 SHALL have port user_reset  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_req  in  NUM_REQ  per-requester "FIFO non-empty" request.
REQ-006 SHALL have port o_tkn  out  NUM_REQ  per-requester one-beat pop token; at most one bit is high.
REQ-007 SHALL have ports i_tvalid / i_tdata / i_tlast / i_tkeep  in  NUM_REQ / NUM_REQ*512 / NUM_REQ / NUM_REQ*16  flattened requester beat, slice n = requester n, driven only while its token is high (zero otherwise).
REQ-008 SHALL have ports m_axis_rq_tvalid / tdata / tlast / tkeep  out  1 / 512 / 1 / 16  PCIe RQ stream.
REQ-009 SHALL have port m_axis_rq_tready  in  1  RQ ready.
REQ-010 SHALL have ports o_busy  out  1 (packet in flight); o_grant_id  out  3 (current owner); o_err_novalid, o_err_overlen  out  1 each (sticky).

Function
REQ-011 SHALL implement a 2-state FSM, ARB and XFER.
REQ-012 In ARB, when any i_req is high, SHALL pick the first requesting index at or after rr_ptr (modulo NUM_REQ), register it as grant, and go to XFER next cycle; with no request it SHALL stay in ARB.
REQ-013 In ARB, o_tkn SHALL be all-zero.
REQ-014 In XFER, o_tkn[grant] SHALL equal i_req[grant] AND m_axis_rq_tready, combinationally; all other token bits SHALL be 0.
REQ-015 Output stream SHALL be the OR of all requester slices, so the granted slice passes with zero latency.
REQ-016 A beat transfers when o_tkn[grant] is high; on a transferred beat with tlast=1, the block SHALL set rr_ptr to grant+1 (wrapping NUM_REQ-1 to 0) and return to ARB, giving a one-cycle bubble between packets.
REQ-017 Grant SHALL be held across mid-packet gaps when i_req[grant] drops; no other requester is served until tlast.
REQ-018 A beat counter SHALL clear in ARB and increment per transferred beat, saturating at 255.
REQ-019 SHALL set o_err_overlen when the count reaches MAX_BEATS without tlast; grant is not released.
REQ-020 SHALL set o_err_novalid if, in any cycle, the granted token is high while i_tvalid[grant] is 0.
REQ-021 o_busy SHALL be 1 exactly in XFER.
REQ-022 o_grant_id SHALL show the registered grant, zero-extended.

Reset
REQ-023 While user_reset is high, the block SHALL force FSM=ARB, grant=0, rr_ptr=0, beat count=0, and clear both error flags; o_tkn=0, o_busy=0, o_grant_id=0.
REQ-024 Reset asserted mid-packet SHALL abandon the packet with no further tokens; requesters are reset by the same user_reset.
REQ-025 Error flags SHALL clear only by reset.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the RQ data/keep width constants (512, 16), and the beat-count width (8).
REQ-027 One sub-module, rq_rr_picker (combinational round-robin select from request vector and rr_ptr, outputs index and valid), SHALL be instantiated.

Verification
REQ-028 Scenario: NUM_REQ=2, req0 alone, 3-beat packet, tready=1 -> grant 0 one cycle after req, tkn0 high 3 consecutive cycles, tlast on beat 3, ARB on next cycle.
REQ-029 Scenario: req0 and req1 both high continuously, 1-beat packets -> grants alternate 0,1,0,1 with one idle cycle between each.
REQ-030 Scenario: tready low 4 cycles mid-packet -> tkn0=0 and m_axis_rq_tvalid=0 for those 4 cycles, data resumes unchanged, no error.
REQ-031 Scenario: i_req[0] drops 2 cycles mid-packet while req1 high -> grant stays 0, req1 served only after tlast of req0.
REQ-032 Scenario: MAX_BEATS=4, 6-beat packet -> o_err_overlen rises when the 4th beat transfers and stays high until reset.
REQ-033 Scenario: reset pulsed during beat 2 of a packet -> next cycle o_tkn=0, o_busy=0, rr_ptr=0; a fresh req1 is then granted first.
